rs_issue_sched: RTL and testbench
=================================

// Module: rs_issue_sched
// PURPOSE
//  Issue scheduler for the reservation station. Each cycle, picks for every functional unit
//  (ALU0, ALU1, MEM) the oldest ready RS entry steered to it, tells the RS which entries to
//  retire, and drives registered issue grants to the FUs.
//  Tracks per-FU occupancy so multi-cycle units are never double-booked.
// PARAMETERS
//  RS_DEPTH   16  number of RS entries (power of 2)
//  ROB_WIDTH  6   ROB tag width; entry age = (tag - rob_head) mod 2^ROB_WIDTH
//  NUM_FU     3   functional units; fixed encoding 0=ALU0, 1=ALU1, 2=MEM
//  MEM_OCC    2   cycles MEM is occupied per grant (1..7)
//  ALU_OCC    1   cycles an ALU is occupied per grant (1..7)
// PORTS
//  clk         in   1                  rising-edge clock
//  rst_n       in   1                  async active-low reset
//  flush       in   1                  sync pipeline flush (branch mispredict)
//  req_valid   in   RS_DEPTH           entry valid AND ready1 AND ready2
//  req_fu      in   2*RS_DEPTH         FU code per entry, entry i at [2i+1:2i]
//  req_tag     in   ROB_WIDTH*RS_DEPTH ROB tag per entry
//  rob_head    in   ROB_WIDTH          tag of oldest in-flight instruction
//  fu_stall    in   NUM_FU             FU cannot accept this cycle
//  clear_vec   out  RS_DEPTH           comb: entries granted this cycle; RS frees them at the edge
//  issue_valid out  NUM_FU             reg: FU f receives an instruction this cycle
//  issue_idx   out  NUM_FU*log2(RS_DEPTH)  reg: RS index issued to FU f
//  fu_free     out  NUM_FU             comb: busy_cnt[f]==0 && !fu_stall[f]
// BEHAVIOUR
//  - Reset (async, rst_n=0): issue_valid=0, issue_idx=0, busy_cnt=0; clear_vec=0 while in reset.
//  - Eligibility: entry i eligible for FU f iff req_valid[i] && req_fu[i]==f && fu_free[f].
//    FU code 3 is never granted and never flagged.
//  - Selection: per FU, choose the eligible entry with minimum age (req_tag - rob_head, ROB_WIDTH
//    bits, wraps naturally). Tags are unique, so ties are impossible. At most one grant per FU;
//    up to NUM_FU grants per cycle. One entry can match only one FU.
//  - Latency: clear_vec is asserted in the selection cycle (combinational).
//    issue_valid/issue_idx register the same selection at the next posedge, i.e. 1 cycle later.
//  - Occupancy: on the grant edge, busy_cnt[f] <= OCC_f-1. When nonzero, it decrements each
//    cycle. With OCC=1 the FU accepts every cycle; with MEM_OCC=2, at most every other cycle.
//  - fu_stall[f]: blocks new grants only. It does not pause busy_cnt. An in-flight issue_valid
//    still presents.
//  - flush=1 at an edge: issue_valid<=0, busy_cnt<=0; clear_vec forced 0 during the flush cycle;
//    no grants are made that cycle. A flush has priority over any pending selection.
//  - Empty (req_valid=0): clear_vec=0 and issue_valid deasserts on the next edge.
//  - The RS must drop cleared entries at the same edge; the scheduler assumes no re-request.
// STRUCTURE
//  - rs_pkg: FU_ALU0/FU_ALU1/FU_MEM codes, FU_W=2, OCC_W=3, and the occupancy table function.
//  - Sub-module rs_age_picker (RS_DEPTH-way oldest-of-N tree; outputs found + index).
//    Instantiated NUM_FU times.
//  - Top level: eligibility masks, busy counters, grant registers, clear_vec OR-reduction.
// TESTING
//  1. rst_n=0 mid-stream with MEM busy -> issue_valid=000, fu_free=111 immediately; idle after release.
//  2. head=0, entry3(tag5,ALU0) + entry7(tag2,ALU0) -> clear_vec=bit7; next cycle issue_valid[0]=1,
//     issue_idx[0]=7; entry3 issues the cycle after.
//  3. Wrap: head=62, entry1 tag63 and entry2 tag1, both MEM -> entry1 granted first.
//  4. MEM_OCC=2, four MEM entries always ready -> MEM grants on cycles 0,2,4,6;
//     fu_free[2]=0 on 1,3,5.
//  5. Entries for ALU0, ALU1 and MEM all ready in one cycle -> clear_vec has 3 bits set;
//     issue_valid=111 next cycle. With fu_stall[1]=1 -> 101, and the ALU1 entry issues one
//     cycle after the stall drops.
//  6. flush asserted the cycle after a MEM grant -> clear_vec=0 that cycle, issue_valid=000 and
//     busy_cnt=0 next edge; a ready MEM entry is granted the following cycle.

Source files
------------

// File: rtl/rs_issue_sched_pkg.sv
// Shared definitions for the reservation-station issue scheduler:
// functional-unit codes, field widths and the per-FU occupancy lookup.
package rs_issue_sched_pkg;

    localparam int FU_W   = 2;
    localparam int OCC_W  = 3;
    localparam int NUM_FU = 3;

    typedef enum logic [FU_W-1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_MEM  = 2'd2,
        FU_NONE = 2'd3
    } fu_code_e;

    // Cycles a unit stays booked after one grant; only MEM differs from the ALUs.
    function automatic logic [OCC_W-1:0] fu_occupancy(input int fu, input int alu_occ,
                                                      input int mem_occ);
        if (fu == int'(FU_MEM)) begin
            return OCC_W'(mem_occ);
        end
        return OCC_W'(alu_occ);
    endfunction

endpackage

// File: rtl/rs_issue_sched_if.sv
// Bundle between the reservation station (master) and the issue scheduler (slave).
// Requests, ROB head, stalls and flush flow in; clear/issue/free flow back.
interface rs_issue_sched_if
    import rs_issue_sched_pkg::*;
#(
    parameter int RS_DEPTH  = 16,
    parameter int ROB_WIDTH = 6,
    parameter int NFU       = 3
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic                          flush;
    logic [RS_DEPTH-1:0]           req_valid;
    logic [FU_W*RS_DEPTH-1:0]      req_fu;
    logic [ROB_WIDTH*RS_DEPTH-1:0] req_tag;
    logic [ROB_WIDTH-1:0]          rob_head;
    logic [NFU-1:0]                fu_stall;

    logic [RS_DEPTH-1:0]           clear_vec;
    logic [NFU-1:0]                issue_valid;
    logic [NFU*IDX_W-1:0]          issue_idx;
    logic [NFU-1:0]                fu_free;

    modport master (
        output flush, req_valid, req_fu, req_tag, rob_head, fu_stall,
        input  clear_vec, issue_valid, issue_idx, fu_free
    );

    modport slave (
        input  flush, req_valid, req_fu, req_tag, rob_head, fu_stall,
        output clear_vec, issue_valid, issue_idx, fu_free
    );

endinterface

// File: rtl/rs_issue_sched_age_picker.sv
// Oldest-of-N selector: a balanced comparison tree over N candidates that
// returns whether any candidate is valid and the index of the smallest age.
module rs_age_picker #(
    parameter int N     = 16,
    parameter int AGE_W = 6,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]       valid,
    input  logic [N*AGE_W-1:0] age,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Heap-ordered tree: leaves occupy nodes N-1..2N-2, each parent keeps the younger-age child.
    always_comb begin : tree
        logic               node_v   [2*N-1];
        logic [AGE_W-1:0]   node_age [2*N-1];
        logic [IDX_W-1:0]   node_idx [2*N-1];
        logic               take_right;
        take_right = 1'b0;
        for (int j = 0; j < N; j++) begin
            node_v[N-1+j]   = valid[j];
            node_age[N-1+j] = age[j*AGE_W +: AGE_W];
            node_idx[N-1+j] = IDX_W'(j);
        end
        for (int i = N-2; i >= 0; i--) begin
            take_right = node_v[2*i+2] &&
                         (!node_v[2*i+1] || (node_age[2*i+2] < node_age[2*i+1]));
            node_v[i]   = node_v[2*i+1] || node_v[2*i+2];
            node_age[i] = take_right ? node_age[2*i+2] : node_age[2*i+1];
            node_idx[i] = take_right ? node_idx[2*i+2] : node_idx[2*i+1];
        end
        found = node_v[0];
        idx   = node_idx[0];
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: per functional unit, grants the oldest
// ready entry steered to it, frees granted entries combinationally, registers
// the grant toward the unit and books multi-cycle units until they are free.
module rs_issue_sched
    import rs_issue_sched_pkg::*;
#(
    parameter int RS_DEPTH  = 16,
    parameter int ROB_WIDTH = 6,
    parameter int MEM_OCC   = 2,
    parameter int ALU_OCC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rs_issue_sched_if.slave  bus
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH*ROB_WIDTH-1:0]       age_vec;
    logic [NUM_FU-1:0]                   fu_free;
    logic [NUM_FU-1:0][RS_DEPTH-1:0]     elig;
    logic [NUM_FU-1:0]                   pick_found;
    logic [NUM_FU-1:0][IDX_W-1:0]        pick_idx;
    logic [RS_DEPTH-1:0]                 clear_vec;

    logic [NUM_FU-1:0][OCC_W-1:0]        busy_cnt;
    logic [NUM_FU-1:0]                   issue_valid_q;
    logic [NUM_FU-1:0][IDX_W-1:0]        issue_idx_q;

    // Age of each entry relative to the ROB head; modular subtraction handles tag wrap.
    always_comb begin
        age_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_vec[i*ROB_WIDTH +: ROB_WIDTH] =
                bus.req_tag[i*ROB_WIDTH +: ROB_WIDTH] - bus.rob_head;
        end
    end

    // A unit can take a new instruction only when its booking has expired and it is not stalled.
    always_comb begin
        fu_free = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_free[f] = (busy_cnt[f] == '0) && !bus.fu_stall[f];
        end
    end

    // Per-unit candidate masks; reset and flush suppress every grant in the cycle.
    always_comb begin
        elig = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                elig[f][i] = rst_n && !bus.flush && fu_free[f] && bus.req_valid[i] &&
                             (bus.req_fu[FU_W*i +: FU_W] == FU_W'(f));
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_FU; g++) begin : g_pick
            rs_age_picker #(
                .N     (RS_DEPTH),
                .AGE_W (ROB_WIDTH),
                .IDX_W (IDX_W)
            ) u_picker (
                .valid (elig[g]),
                .age   (age_vec),
                .found (pick_found[g]),
                .idx   (pick_idx[g])
            );
        end
    endgenerate

    // Entries granted this cycle, one bit per winning unit, so the RS can free them at the edge.
    always_comb begin
        clear_vec = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (pick_found[f]) begin
                clear_vec[pick_idx[f]] = 1'b1;
            end
        end
    end

    // Registered grants toward the units plus per-unit occupancy countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= '0;
            issue_idx_q   <= '0;
            busy_cnt      <= '0;
        end else if (bus.flush) begin
            issue_valid_q <= '0;
            busy_cnt      <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                issue_valid_q[f] <= pick_found[f];
                if (pick_found[f]) begin
                    issue_idx_q[f] <= pick_idx[f];
                    busy_cnt[f]    <= fu_occupancy(f, ALU_OCC, MEM_OCC) - OCC_W'(1);
                end else if (busy_cnt[f] != '0) begin
                    busy_cnt[f] <= busy_cnt[f] - OCC_W'(1);
                end
            end
        end
    end

    assign bus.clear_vec   = clear_vec;
    assign bus.fu_free     = fu_free;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_idx   = issue_idx_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed scoreboard bench for rs_issue_sched: the stimulus process pushes the
// hand-computed expected outputs for each cycle, a monitor pops and compares them.
module tb_rs_issue_sched;
    import rs_issue_sched_pkg::*;

    localparam int DEPTH = 16;
    localparam int RW    = 6;

    typedef struct {
        string       name;
        logic [15:0] clr;
        logic [2:0]  free;
        logic [2:0]  iv;
        logic [2:0]  idx_mask;
        logic [11:0] idx;
    } exp_t;

    logic clk;
    logic rst_n;

    rs_issue_sched_if #(.RS_DEPTH(DEPTH), .ROB_WIDTH(RW), .NFU(3)) bus ();

    rs_issue_sched #(
        .RS_DEPTH  (DEPTH),
        .ROB_WIDTH (RW),
        .MEM_OCC   (2),
        .ALU_OCC   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t              sb [$];
    int                n_vectors;
    int                n_miscompares;

    logic              rst_drv;
    logic              flush_drv;
    logic [DEPTH-1:0]  rv;
    logic [2*DEPTH-1:0] rf;
    logic [RW*DEPTH-1:0] rt;
    logic [RW-1:0]     head;
    logic [2:0]        stall;

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_bus();
        rst_n        = rst_drv;
        bus.flush    = flush_drv;
        bus.req_valid = rv;
        bus.req_fu   = rf;
        bus.req_tag  = rt;
        bus.rob_head = head;
        bus.fu_stall = stall;
    endtask

    task automatic clear_entries();
        rv = '0;
        rf = '1;
        rt = '0;
    endtask

    task automatic set_entry(input int i, input logic [1:0] fu, input logic [RW-1:0] tag);
        rv[i]          = 1'b1;
        rf[2*i +: 2]   = fu;
        rt[RW*i +: RW] = tag;
    endtask

    task automatic drop_entry(input int i);
        rv[i]        = 1'b0;
        rf[2*i +: 2] = 2'd3;
    endtask

    // Drive one cycle of inputs after the edge and queue what the DUT must show in that cycle.
    task automatic apply_stimulus(input string name, input logic [15:0] clr,
                                  input logic [2:0] free, input logic [2:0] iv,
                                  input logic [3:0] i0, input logic [3:0] i1,
                                  input logic [3:0] i2);
        exp_t e;
        @(posedge clk);
        #1;
        drive_bus();
        e.name     = name;
        e.clr      = clr;
        e.free     = free;
        e.iv       = iv;
        e.idx_mask = rst_drv ? iv : 3'b111;
        e.idx      = {i2, i1, i0};
        sb.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        n_vectors++;
        if (bus.clear_vec !== e.clr) begin
            n_miscompares++;
            $display("[TB] FAIL %s clear_vec: got %h want %h", e.name, bus.clear_vec, e.clr);
        end
        n_vectors++;
        if (bus.fu_free !== e.free) begin
            n_miscompares++;
            $display("[TB] FAIL %s fu_free: got %b want %b", e.name, bus.fu_free, e.free);
        end
        n_vectors++;
        if (bus.issue_valid !== e.iv) begin
            n_miscompares++;
            $display("[TB] FAIL %s issue_valid: got %b want %b", e.name, bus.issue_valid, e.iv);
        end
        for (int f = 0; f < 3; f++) begin
            if (e.idx_mask[f]) begin
                n_vectors++;
                if (bus.issue_idx[4*f +: 4] !== e.idx[4*f +: 4]) begin
                    n_miscompares++;
                    $display("[TB] FAIL %s issue_idx[%0d]: got %0d want %0d", e.name, f,
                             bus.issue_idx[4*f +: 4], e.idx[4*f +: 4]);
                end
            end
        end
    endtask

    // Monitor: compare every cycle that has a queued expectation, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output(e);
            end
        end
    end

    // Directed stimulus.
    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst_drv   = 1'b0;
        flush_drv = 1'b0;
        head      = '0;
        stall     = '0;
        clear_entries();
        drive_bus();

        apply_stimulus("reset",      16'h0000, 3'b111, 3'b000, 0, 0, 0);
        apply_stimulus("reset_hold", 16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // Oldest-first among two ALU0 entries.
        rst_drv = 1'b1;
        set_entry(3, FU_ALU0, 6'd5);
        set_entry(7, FU_ALU0, 6'd2);
        apply_stimulus("age_first",  16'h0080, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(7);
        apply_stimulus("age_second", 16'h0008, 3'b111, 3'b001, 7, 0, 0);
        drop_entry(3);
        apply_stimulus("age_issue3", 16'h0000, 3'b111, 3'b001, 3, 0, 0);
        apply_stimulus("age_idle",   16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // Tag wrap: head 62, tag 63 (age 1) is older than tag 1 (age 3).
        head = 6'd62;
        set_entry(1, FU_MEM, 6'd63);
        set_entry(2, FU_MEM, 6'd1);
        apply_stimulus("wrap_first", 16'h0002, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(1);
        apply_stimulus("wrap_busy",  16'h0000, 3'b011, 3'b100, 0, 0, 1);
        apply_stimulus("wrap_second",16'h0004, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(2);
        apply_stimulus("wrap_issue2",16'h0000, 3'b011, 3'b100, 0, 0, 2);
        apply_stimulus("wrap_idle",  16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // MEM occupancy of two: grants every other cycle.
        head = 6'd0;
        set_entry(4, FU_MEM, 6'd10);
        set_entry(5, FU_MEM, 6'd11);
        set_entry(6, FU_MEM, 6'd12);
        set_entry(8, FU_MEM, 6'd13);
        apply_stimulus("mem_c0", 16'h0010, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(4);
        apply_stimulus("mem_c1", 16'h0000, 3'b011, 3'b100, 0, 0, 4);
        apply_stimulus("mem_c2", 16'h0020, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(5);
        apply_stimulus("mem_c3", 16'h0000, 3'b011, 3'b100, 0, 0, 5);
        apply_stimulus("mem_c4", 16'h0040, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(6);
        apply_stimulus("mem_c5", 16'h0000, 3'b011, 3'b100, 0, 0, 6);
        apply_stimulus("mem_c6", 16'h0100, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(8);
        apply_stimulus("mem_c7", 16'h0000, 3'b011, 3'b100, 0, 0, 8);
        apply_stimulus("mem_c8", 16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // Three units granted in one cycle.
        set_entry(0,  FU_ALU0, 6'd20);
        set_entry(9,  FU_ALU1, 6'd21);
        set_entry(12, FU_MEM,  6'd22);
        apply_stimulus("tri_grant", 16'h1201, 3'b111, 3'b000, 0, 0, 0);
        clear_entries();
        apply_stimulus("tri_issue", 16'h0000, 3'b011, 3'b111, 0, 9, 12);
        apply_stimulus("tri_idle",  16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // ALU1 stalled: only ALU0 and MEM go, ALU1 follows once the stall drops.
        set_entry(1,  FU_ALU0, 6'd30);
        set_entry(10, FU_ALU1, 6'd31);
        set_entry(13, FU_MEM,  6'd32);
        stall = 3'b010;
        apply_stimulus("stall_grant", 16'h2002, 3'b101, 3'b000, 0, 0, 0);
        drop_entry(1);
        drop_entry(13);
        apply_stimulus("stall_issue", 16'h0000, 3'b001, 3'b101, 1, 0, 13);
        stall = 3'b000;
        apply_stimulus("stall_drop",  16'h0400, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(10);
        apply_stimulus("stall_alu1",  16'h0000, 3'b111, 3'b010, 0, 10, 0);
        apply_stimulus("stall_idle",  16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // Flush the cycle after a MEM grant; the ALU0 selection that cycle is suppressed.
        set_entry(14, FU_MEM, 6'd40);
        apply_stimulus("flush_pre",   16'h4000, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(14);
        set_entry(15, FU_MEM,  6'd41);
        set_entry(0,  FU_ALU0, 6'd42);
        flush_drv = 1'b1;
        apply_stimulus("flush_cycle", 16'h0000, 3'b011, 3'b100, 0, 0, 14);
        flush_drv = 1'b0;
        apply_stimulus("flush_after", 16'h8001, 3'b111, 3'b000, 0, 0, 0);
        clear_entries();
        apply_stimulus("flush_issue", 16'h0000, 3'b011, 3'b101, 0, 0, 15);
        apply_stimulus("flush_idle",  16'h0000, 3'b111, 3'b000, 0, 0, 0);

        // Asynchronous reset while MEM is busy and an ALU0 entry is ready.
        set_entry(11, FU_MEM, 6'd50);
        apply_stimulus("rst_pre",     16'h0800, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(11);
        set_entry(2, FU_ALU0, 6'd51);
        rst_drv = 1'b0;
        apply_stimulus("rst_mid",     16'h0000, 3'b111, 3'b000, 0, 0, 0);
        drop_entry(2);
        rst_drv = 1'b1;
        apply_stimulus("rst_release", 16'h0000, 3'b111, 3'b000, 0, 0, 0);
        apply_stimulus("rst_idle",    16'h0000, 3'b111, 3'b000, 0, 0, 0);

        @(negedge clk);
        #1;
        n_vectors++;
        if (sb.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
